// File: rtl/johnson_counter_p_if.sv
// Control/status bundle for the parametrised Johnson counter.
// The controller uses the master modport and the counter uses the slave modport.
interface johnson_counter_p_if #(
  parameter int unsigned WIDTH = 4
) ();
  localparam int unsigned IDX_W = $clog2(2 * WIDTH);

  logic               en;
  logic               dir;
  logic               load;
  logic [IDX_W-1:0]   load_idx;
  logic [WIDTH-1:0]   count;
  logic [IDX_W-1:0]   idx;
  logic [2*WIDTH-1:0] phase;
  logic               wrap;
  logic               err;

  modport master (
    output en, dir, load, load_idx,
    input  count, idx, phase, wrap, err
  );

  modport slave (
    input  en, dir, load, load_idx,
    output count, idx, phase, wrap, err
  );
endinterface

// File: rtl/johnson_counter_p.sv
// Parametrised Johnson counter with up/down stepping, index load, one-hot phase decode,
// a wrap pulse, and self-correction of illegal codes.
module johnson_counter_p #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_IDX = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  johnson_counter_p_if.slave bus
);
  localparam int unsigned NSTATES = 2 * WIDTH;
  localparam int unsigned IDX_W   = $clog2(NSTATES);
  localparam logic [IDX_W:0]   NSTATES_V = (IDX_W+1)'(NSTATES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NSTATES - 1);
  localparam logic [IDX_W-1:0] RST_IDX_V = IDX_W'(RST_IDX);

  // Johnson code for sequence index k: low k ones up to WIDTH, then a shrinking high block.
  function automatic logic [WIDTH-1:0] code(input int unsigned k);
    logic [WIDTH-1:0] c;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
    end
    return c;
  endfunction

  function automatic logic [NSTATES-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [NSTATES-1:0] p;
    p    = '0;
    p[k] = 1'b1;
    return p;
  endfunction

  logic [WIDTH-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NSTATES-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               legal_c;
  logic               load_ok_c;
  logic [WIDTH-1:0]   inv_c;

  // Legal codes are a block of ones anchored at bit 0 or at bit WIDTH-1.
  always_comb begin
    inv_c     = ~count_q;
    legal_c   = ((count_q & (count_q + WIDTH'(1))) == '0) ||
                ((inv_c & (inv_c + WIDTH'(1))) == '0);
    load_ok_c = {1'b0, bus.load_idx} < NSTATES_V;
  end

  always_comb begin
    count_d = count_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok_c) begin
        count_d = code(32'(bus.load_idx));
        idx_d   = bus.load_idx;
        phase_d = onehot(bus.load_idx);
      end else begin
        err_d = 1'b1;
      end
    end else if (!legal_c) begin
      count_d = '0;
      idx_d   = '0;
      phase_d = onehot('0);
      err_d   = 1'b1;
    end else if (bus.en) begin
      if (!bus.dir) begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        wrap_d  = (idx_q == LAST_IDX);
      end else begin
        count_d = {~count_q[0], count_q[WIDTH-1:1]};
        idx_d   = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        wrap_d  = (idx_q == '0);
      end
      phase_d = onehot(idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q <= code(RST_IDX);
      idx_q   <= RST_IDX_V;
      phase_q <= onehot(RST_IDX_V);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count = count_q;
  assign bus.idx   = idx_q;
  assign bus.phase = phase_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_johnson_counter_p.sv
// Directed bench for johnson_counter_p: a WIDTH=4 instance for sequencing and correction,
// and a WIDTH=3 instance for out-of-range loads.
module tb_johnson_counter_p;
  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  johnson_counter_p_if #(.WIDTH(4)) b4 ();
  johnson_counter_p_if #(.WIDTH(3)) b3 ();

  johnson_counter_p #(.WIDTH(4), .RST_IDX(0)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (b4.slave)
  );

  johnson_counter_p #(.WIDTH(3), .RST_IDX(0)) dut3 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] fwd_cnt [9];
  logic [2:0] fwd_idx [9];
  logic       fwd_wrap[9];
  logic [3:0] rev_cnt [3];
  logic [2:0] rev_idx [3];
  logic       rev_wrap[3];

  initial begin
    checks = 0;
    errors = 0;
    fwd_cnt  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
    fwd_idx  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    fwd_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rev_cnt  = '{4'h8, 4'hC, 4'hE};
    rev_idx  = '{3'd7, 3'd6, 3'd5};
    rev_wrap = '{1'b1, 1'b0, 1'b0};

    n_rst = 1'b0;
    b4.en = 1'b0; b4.dir = 1'b0; b4.load = 1'b0; b4.load_idx = '0;
    b3.en = 1'b0; b3.dir = 1'b0; b3.load = 1'b0; b3.load_idx = '0;
    step();
    step();
    chk("rst_count", 32'(b4.count), 32'h0);
    chk("rst_idx",   32'(b4.idx),   32'h0);
    chk("rst_phase", 32'(b4.phase), 32'h01);
    chk("rst_wrap",  32'(b4.wrap),  32'h0);
    chk("rst_err",   32'(b4.err),   32'h0);

    // Forward run through a full cycle plus one.
    n_rst = 1'b1;
    b4.en = 1'b1; b4.dir = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("fwd_count_%0d", i), 32'(b4.count), 32'(fwd_cnt[i]));
      chk($sformatf("fwd_idx_%0d", i),   32'(b4.idx),   32'(fwd_idx[i]));
      chk($sformatf("fwd_phase_%0d", i), 32'(b4.phase), 32'h1 << fwd_idx[i]);
      chk($sformatf("fwd_wrap_%0d", i),  32'(b4.wrap),  32'(fwd_wrap[i]));
    end

    // Back to idx 0, then reverse through the wrap.
    b4.dir = 1'b1;
    step();
    chk("rev_start_count", 32'(b4.count), 32'h0);
    chk("rev_start_wrap",  32'(b4.wrap),  32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rev_count_%0d", i), 32'(b4.count), 32'(rev_cnt[i]));
      chk($sformatf("rev_idx_%0d", i),   32'(b4.idx),   32'(rev_idx[i]));
      chk($sformatf("rev_wrap_%0d", i),  32'(b4.wrap),  32'(rev_wrap[i]));
    end

    // Load beats enable.
    b4.load = 1'b1; b4.load_idx = 3'd5; b4.en = 1'b1; b4.dir = 1'b0;
    step();
    chk("load_count", 32'(b4.count), 32'hE);
    chk("load_idx",   32'(b4.idx),   32'd5);
    chk("load_phase", 32'(b4.phase), 32'h20);
    chk("load_wrap",  32'(b4.wrap),  32'h0);
    chk("load_err",   32'(b4.err),   32'h0);
    b4.load = 1'b0;
    step();
    chk("post_load_count", 32'(b4.count), 32'hC);
    chk("post_load_idx",   32'(b4.idx),   32'd6);

    // Corrupt the ring and expect correction to index 0.
    b4.en = 1'b0;
    force dut.count_q = 4'b0101;
    #1;
    release dut.count_q;
    step();
    chk("fix_count", 32'(b4.count), 32'h0);
    chk("fix_idx",   32'(b4.idx),   32'h0);
    chk("fix_phase", 32'(b4.phase), 32'h01);
    chk("fix_err",   32'(b4.err),   32'h1);
    chk("fix_wrap",  32'(b4.wrap),  32'h0);
    step();
    chk("fix_err_clear", 32'(b4.err),   32'h0);
    chk("fix_hold",      32'(b4.count), 32'h0);

    // Enable toggling with alternating direction.
    b4.en = 1'b1; b4.dir = 1'b0;
    step();
    chk("tog0_count", 32'(b4.count), 32'h1);
    b4.en = 1'b0; b4.dir = 1'b1;
    step();
    chk("tog1_count", 32'(b4.count), 32'h1);
    chk("tog1_idx",   32'(b4.idx),   32'd1);
    b4.en = 1'b1; b4.dir = 1'b1;
    step();
    chk("tog2_count", 32'(b4.count), 32'h0);
    chk("tog2_wrap",  32'(b4.wrap),  32'h0);
    b4.en = 1'b0; b4.dir = 1'b0;
    step();
    chk("tog3_idx",  32'(b4.idx),  32'd0);
    chk("tog3_wrap", 32'(b4.wrap), 32'h0);

    // Reset mid-sequence with enable high.
    b4.load = 1'b1; b4.load_idx = 3'd6;
    step();
    b4.load = 1'b0;
    chk("pre_rst_count", 32'(b4.count), 32'hC);
    b4.en = 1'b1; n_rst = 1'b0;
    step();
    chk("mid_rst_count", 32'(b4.count), 32'h0);
    chk("mid_rst_idx",   32'(b4.idx),   32'd0);
    chk("mid_rst_wrap",  32'(b4.wrap),  32'h0);
    chk("mid_rst_err",   32'(b4.err),   32'h0);
    n_rst = 1'b1;
    step();
    chk("resume_count", 32'(b4.count), 32'h1);
    b4.en = 1'b0;

    // WIDTH=3: out-of-range loads are rejected with err.
    b3.load = 1'b1; b3.load_idx = 3'd2;
    step();
    chk("w3_load_count", 32'(b3.count), 32'h3);
    b3.load_idx = 3'd7;
    step();
    chk("w3_bad_count", 32'(b3.count), 32'h3);
    chk("w3_bad_idx",   32'(b3.idx),   32'd2);
    chk("w3_bad_err",   32'(b3.err),   32'h1);
    b3.load = 1'b0;
    step();
    chk("w3_err_clear", 32'(b3.err), 32'h0);
    b3.load = 1'b1; b3.load_idx = 3'd6;
    step();
    chk("w3_bad6_err",  32'(b3.err),   32'h1);
    chk("w3_bad6_hold", 32'(b3.count), 32'h3);
    b3.load_idx = 3'd0;
    step();
    b3.load = 1'b0; b3.en = 1'b1; b3.dir = 1'b1;
    step();
    chk("w3_rev_count", 32'(b3.count), 32'h4);
    chk("w3_rev_idx",   32'(b3.idx),   32'd5);
    chk("w3_rev_wrap",  32'(b3.wrap),  32'h1);
    chk("w3_rev_phase", 32'(b3.phase), 32'h20);
    b3.en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/johnson_counter_p.md
Name: johnson_counter_p

Overview:
- Parametrised Johnson (twisted-ring) counter. It is the generalised successor of the fixed 4-bit Johnson counter.
- Adds:
  - width parameter
  - step enable
  - up/down direction
  - synchronous index load
  - decoded one-hot phase and binary index outputs
  - wrap pulse
  - illegal-state self-correction with an error flag
- Used as a multi-phase sequencer and clock-phase generator. Phase outputs drive downstream strobes directly.

Parameters:
- WIDTH, 4, ring length in flops; the sequence has 2*WIDTH states; legal range 2..16.
- RST_IDX, 0, sequence index loaded on reset; must be < 2*WIDTH.
- Localparam IDX_W = $clog2(2*WIDTH), width of index ports.

Ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  synchronous active-low reset
- en  input  1  step enable; one step per clock while high
- dir  input  1  0 = forward (index +1), 1 = reverse (index -1)
- load  input  1  synchronous load of load_idx; has priority over en
- load_idx  input  IDX_W  target sequence index for load
- count  output  WIDTH  Johnson code, registered
- idx  output  IDX_W  binary index of count, registered, always consistent with count
- phase  output  2*WIDTH  one-hot decode of idx (phase[idx]=1), registered
- wrap  output  1  one-cycle pulse on sequence wrap
- err  output  1  one-cycle pulse on illegal load index or illegal count detected

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: n_rst sampled low at a rising edge of clk resets the block. No asynchronous reset path.
- Code mapping, index k, 0 <= k < 2*WIDTH:
  - k <= WIDTH: count = low k bits set.
  - k > WIDTH: count = high (2*WIDTH-k) bits set, rest clear.
  - WIDTH=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Forward step: count <= {count[WIDTH-2:0], ~count[WIDTH-1]}; idx <= idx+1 mod 2*WIDTH.
- Reverse step: count <= {~count[0], count[WIDTH-1:1]}; idx <= idx-1 mod 2*WIDTH.
- Reset: count = code(RST_IDX), idx = RST_IDX, phase = one-hot(RST_IDX), wrap = 0, err = 0.
- Per-edge priority, highest first:
  - 1. n_rst low → reset values.
  - 2. load high:
    - load_idx < 2*WIDTH → count/idx/phase take load_idx; wrap = 0; err = 0.
    - load_idx >= 2*WIDTH (only possible when 2*WIDTH is not a power of two) → state held, err = 1.
  - 3. count is not a legal Johnson code (e.g. SEU or forced value) → count = code(0), idx = 0, phase[0] = 1, err = 1. Applies regardless of en.
  - 4. en high → one step in direction dir.
  - 5. Otherwise hold.
- Step timing: one step per enabled edge; outputs update on the same edge, so latency from en sampled to new count is 1 cycle. dir may change every cycle and takes effect on the edge it is sampled.
- wrap:
  - Asserted for the cycle following an edge that stepped forward from idx 2*WIDTH-1 to 0, or reverse from 0 to 2*WIDTH-1.
  - Never asserted on load, correction or reset.
- err: deasserts on the next edge unless its condition recurs.
- Legality check: count is legal iff it has at most one 0→1 transition when read as a ring. Equivalently, it equals code(k) for some k. The check is combinational on the current count.
- Invariant: phase is exactly one-hot and matches idx at all times after reset, including after correction.
- Reset mid-sequence (n_rst low while en high) → reset values on that edge; stepping resumes on the first edge with n_rst high.

Test Plan (WIDTH=4, RST_IDX=0):
- Reset then en=1, dir=0 for 9 cycles:
  - count visits 0000→0001→0011→0111→1111→1110→1100→1000→0000→0001.
  - phase tracks one-hot of idx 1..7,0,1.
  - wrap high exactly in the cycle count returns to 0000.
- From idx 0, en=1, dir=1 for 3 cycles:
  - count 1000, 1100, 1110; idx 7, 6, 5.
  - wrap high only in the cycle of 1000.
- load=1, load_idx=5, en=1 in the same cycle:
  - count=1110, idx=5; en ignored; no wrap, no err.
  - Next edge with en=1, dir=0 → count=1100.
- Force count to 0101 for one cycle with en=0:
  - Next edge count=0000, idx=0, phase=00000001.
  - err pulses high for exactly one cycle.
- en toggled 1,0,1,0 with dir alternating 0,1:
  - count holds on en=0 cycles.
  - Net index returns to start; no wrap.
- Assert n_rst=0 at idx 6 with en=1:
  - Next edge count=0000, wrap=0, err=0.
  - With WIDTH=3 (6 states): load_idx=7 → state held, err=1 for one cycle.
